// File: rtl/fifo_pop_arbiter_pkg.sv
// Shared definitions for the FIFO drain-side arbiter: state encoding, port count,
// destination-field positions and pop counter width.
package fifo_pop_arbiter_pkg;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2,
        ST_ERROR = 2'd3
    } state_e;

    // Destination field occupies the two most significant bits of a word.
    function automatic int dest_msb(input int data_size);
        return data_size - 1;
    endfunction

    function automatic int dest_lsb(input int data_size);
        return data_size - 2;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first requester after last_i, wrapping modulo NUM_PORTS.
module rr_grant
    import fifo_pop_arbiter_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    last_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PORT_W-1:0]    idx_o
);

    logic              found;
    logic [PORT_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = last_i;
        found = 1'b0;
        cand  = '0;
        // k == NUM_PORTS wraps back to last_i, so a lone requester can win repeatedly.
        for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = last_i + PORT_W'(k);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                idx_o        = cand;
                gnt_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_pop_arbiter.sv
// Pops four input FIFOs round-robin and routes each word by its top two bits to one of four
// output FIFOs, read-to-write latency 2; optional per-input pop counters under POP_COUNT_EN.
module fifo_pop_arbiter
    import fifo_pop_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           fifo_empty_in,
    input  logic [NUM_PORTS*DATA_SIZE-1:0] data_out_pop_in,
    output logic [NUM_PORTS-1:0]           read_out,
    input  logic [NUM_PORTS-1:0]           almost_full_out_in,
    input  logic [NUM_PORTS-1:0]           fifo_pause_out_in,
    input  logic [NUM_PORTS-1:0]           fifo_error_out_in,
    output logic [NUM_PORTS-1:0]           write_out,
    output logic [DATA_SIZE-1:0]           data_in_push_out,
    output logic                           arb_error
`ifdef POP_COUNT_EN
    ,
    output logic [NUM_PORTS*CNT_W-1:0]     pop_count
`endif
);

    localparam int DMSB = dest_msb(DATA_SIZE);
    localparam int DLSB = dest_lsb(DATA_SIZE);

    state_e                 state_q, state_d;
    logic [PORT_W-1:0]      last_q;
    logic                   pend_vld_q;
    logic [PORT_W-1:0]      pend_idx_q;
    logic [NUM_PORTS-1:0]   write_q;
    logic [DATA_SIZE-1:0]   data_q;

    logic [NUM_PORTS-1:0]   req;
    logic [NUM_PORTS-1:0]   gnt;
    logic [PORT_W-1:0]      gnt_idx;
    logic                   bp;
    logic                   err;
    logic [DATA_SIZE-1:0]   pend_word;

    assign req       = ~fifo_empty_in;
    assign bp        = |almost_full_out_in || |fifo_pause_out_in;
    assign err       = |fifo_error_out_in;
    assign pend_word = data_out_pop_in[int'(pend_idx_q)*DATA_SIZE +: DATA_SIZE];

    rr_grant u_rr_grant (
        .req_i  (req),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    // Pop strobe is combinational so backpressure or an error blocks it in the same cycle.
    always_comb begin
        state_d  = state_q;
        read_out = '0;
        case (state_q)
            ST_IDLE: begin
                if (|req && !bp) state_d = ST_GRANT;
            end
            ST_GRANT: begin
                if (bp) begin
                    state_d = ST_HOLD;
                end else begin
                    read_out = gnt;
                    if (!(|req)) state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!bp) state_d = |req ? ST_GRANT : ST_IDLE;
            end
            default: state_d = ST_ERROR;
        endcase
        if (err) begin
            state_d  = ST_ERROR;
            read_out = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= PORT_W'(NUM_PORTS - 1);
            pend_vld_q <= 1'b0;
            pend_idx_q <= '0;
            write_q    <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_vld_q <= |read_out;
            pend_idx_q <= gnt_idx;
            if (|read_out) last_q <= gnt_idx;
            // In-flight words complete regardless of HOLD or ERROR.
            write_q <= '0;
            if (pend_vld_q) begin
                write_q[pend_word[DMSB:DLSB]] <= 1'b1;
                data_q                        <= pend_word;
            end
        end
    end

    assign write_out        = write_q;
    assign data_in_push_out = data_q;
    assign arb_error        = (state_q == ST_ERROR);

`ifdef POP_COUNT_EN
    logic [NUM_PORTS-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (read_out[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign pop_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_pop_arbiter.sv
// Scoreboard bench for fifo_pop_arbiter: behavioural input FIFOs, round-robin model and
// per-word routing/latency checks; pop counters compared when POP_COUNT_EN is defined.
module tb_fifo_pop_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fifo_empty_in;
    logic [31:0] data_out_pop_in;
    logic [3:0]  read_out;
    logic [3:0]  almost_full_out_in;
    logic [3:0]  fifo_pause_out_in;
    logic [3:0]  fifo_error_out_in;
    logic [3:0]  write_out;
    logic [7:0]  data_in_push_out;
    logic        arb_error;
`ifdef POP_COUNT_EN
    logic [63:0] pop_count;
`endif

    fifo_pop_arbiter #(.DATA_SIZE(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .fifo_empty_in      (fifo_empty_in),
        .data_out_pop_in    (data_out_pop_in),
        .read_out           (read_out),
        .almost_full_out_in (almost_full_out_in),
        .fifo_pause_out_in  (fifo_pause_out_in),
        .fifo_error_out_in  (fifo_error_out_in),
        .write_out          (write_out),
        .data_in_push_out   (data_in_push_out),
        .arb_error          (arb_error)
`ifdef POP_COUNT_EN
        ,
        .pop_count          (pop_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] inq[4][$];
    logic [7:0] dreg[4];
    logic [3:0] af_n, pa_n, fe_n, rd_s;
    int         last_m;
    bit         err_m;
    int         cnt_m[4];
    int         passes = 0;
    int         total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < 4; i++) begin
            fifo_empty_in[i]          = (inq[i].size() == 0);
            data_out_pop_in[i*8 +: 8] = dreg[i];
        end
        almost_full_out_in = af_n;
        fifo_pause_out_in  = pa_n;
        fifo_error_out_in  = fe_n;
    endtask

    // Runs just before the active edge: what read_out shows now is what the DUT commits.
    task automatic sample();
        int e;
        rd_s = read_out;
        if (|af_n || |pa_n || |fe_n || err_m) begin
            chk("pop_blocked", {60'd0, read_out}, 64'd0);
        end else if (read_out != 4'd0) begin
            e = -1;
            for (int k = 1; k <= 4; k++) begin
                if (e < 0 && inq[(last_m + k) % 4].size() > 0) e = (last_m + k) % 4;
            end
            chk("rr_grant", {60'd0, read_out}, (e < 0) ? 64'd0 : (64'd1 << e));
            if (e >= 0) begin
                last_m = e;
                cnt_m[e]++;
                sb.push_back('{inq[e][0], cyc + 2});
            end
        end
        if (|fe_n) err_m = 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (rd_s[i] && inq[i].size() > 0) dreg[i] = inq[i].pop_front();
        drive_inputs();
        #4;
        sample();
    endtask

    task automatic wait_grant(input string nm);
        int w = 0;
        while (rd_s == 4'd0 && w < 8) begin
            step();
            w++;
        end
        if (rd_s == 4'd0) chk(nm, 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            if (rd_s[i] && inq[i].size() > 0) dreg[i] = inq[i].pop_front();
        drive_inputs();
        #2 reset = 1'b1;
        #1;
        chk("rst_read_out", {60'd0, read_out}, 64'd0);
        chk("rst_write_out", {60'd0, write_out}, 64'd0);
        chk("rst_data", {56'd0, data_in_push_out}, 64'd0);
        chk("rst_arb_error", {63'd0, arb_error}, 64'd0);
        sb.delete();
        rd_s   = '0;
        last_m = 3;
        err_m  = 1'b0;
        af_n   = '0;
        pa_n   = '0;
        fe_n   = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_m[i] = 0;
            inq[i].delete();
            dreg[i] = '0;
        end
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic fill_all(input int n);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < n; k++) inq[i].push_back(8'($urandom));
    endtask

    // Monitor: every write must match the oldest outstanding pop, exactly two cycles later.
    always @(negedge clk) begin
        exp_t e;
        if (write_out != 4'd0) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", {60'd0, write_out}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("wr_data", {56'd0, data_in_push_out}, {56'd0, e.d});
                chk("wr_route", {60'd0, write_out}, 64'd1 << e.d[7:6]);
                chk("wr_latency", 64'(cyc), 64'(e.due));
            end
        end else if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            chk("wr_missing", 64'(cyc), 64'(e.due));
        end
    end

    initial begin
        logic [7:0] sp_words[3];
        int w;
        sp_words = '{8'h00, 8'h41, 8'h82};
        reset  = 1'b1;
        rd_s   = '0;
        af_n   = '0;
        pa_n   = '0;
        fe_n   = '0;
        last_m = 3;
        err_m  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dreg[i]  = '0;
            cnt_m[i] = 0;
        end
        drive_inputs();
        do_reset();

        // Single port, three back-to-back pops routed to outputs 0,1,2.
        for (int k = 0; k < 3; k++) inq[0].push_back(sp_words[k]);
        wait_grant("sp_timeout");
        chk("sp_pop1", {60'd0, rd_s}, 64'd1);
        step();
        chk("sp_pop2", {60'd0, rd_s}, 64'd1);
        step();
        chk("sp_pop3", {60'd0, rd_s}, 64'd1);
        step();
        chk("sp_done", {60'd0, rd_s}, 64'd0);
        repeat (3) step();
        chk("sp_drained", 64'(sb.size()), 64'd0);

        // Fairness: 0,1,2,3,0 with no gap.
        do_reset();
        fill_all(2);
        wait_grant("fair_timeout");
        for (int k = 0; k < 5; k++) begin
            chk("fair_seq", {60'd0, rd_s}, 64'd1 << (k % 4));
            step();
        end

        // Backpressure mid-stream.
        fill_all(4);
        step();
        step();
        af_n[2] = 1'b1;
        step();
        chk("bp_block", {60'd0, rd_s}, 64'd0);
        repeat (3) step();
        af_n = '0;
        step();
        chk("bp_release_hold", {60'd0, rd_s}, 64'd0);
        step();
        chk("bp_resume", {63'd0, rd_s != 4'd0}, 64'd1);
        step();

        // Error pulse: sticky flag, no further pops, in-flight words still land.
        fe_n[1] = 1'b1;
        step();
        fe_n = '0;
        step();
        chk("err_flag", {63'd0, arb_error}, 64'd1);
        repeat (5) step();
        chk("err_sticky", {63'd0, arb_error}, 64'd1);
        chk("err_inflight_done", 64'(sb.size()), 64'd0);

        // Reset while words are in flight.
        do_reset();
        fill_all(3);
        wait_grant("rst_ms_timeout");
        step();
        do_reset();
        chk("rst_ms_sb_clear", 64'(sb.size()), 64'd0);
        fill_all(2);
        wait_grant("rst_first_timeout");
        chk("rst_first_port0", {60'd0, rd_s}, 64'd1);
        repeat (12) step();

`ifdef POP_COUNT_EN
        do_reset();
        for (int k = 0; k < 5; k++) inq[3].push_back(8'($urandom));
        repeat (10) step();
        chk("pop_count_p3", pop_count, {16'd5, 48'd0});
`endif

        // Randomised traffic with sporadic backpressure.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 2) == 0 && inq[i].size() < 6) inq[i].push_back(8'($urandom));
            af_n = ($urandom_range(0, 9) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            pa_n = ($urandom_range(0, 11) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            step();
        end
        af_n = '0;
        pa_n = '0;
        w = 0;
        while (w < 200 && (sb.size() != 0 || inq[0].size() != 0 || inq[1].size() != 0 ||
                           inq[2].size() != 0 || inq[3].size() != 0)) begin
            step();
            w++;
        end
        repeat (3) step();
        chk("rand_drained", 64'(sb.size() + inq[0].size() + inq[1].size() + inq[2].size() + inq[3].size()), 64'd0);
        chk("rand_some_pops", {63'd0, (cnt_m[0] + cnt_m[1] + cnt_m[2] + cnt_m[3]) > 100}, 64'd1);
`ifdef POP_COUNT_EN
        for (int i = 0; i < 4; i++)
            chk("pop_count_rand", {48'd0, pop_count[i*16 +: 16]}, 64'(cnt_m[i] & 16'hFFFF));
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
